sha256_nonce_engine: RTL and testbench

Downstream hashing stage of the Bitcoin hasher. It receives the first-block midstate and the three tail header words that the memory-reading front end captures. For each nonce 0..NUM_NONCES-1 it runs the second-block SHA-256 compression, then the final SHA-256 over the 256-bit result. Each nonce's final H0 word goes out on a valid/ready stream, so the front end can write it to memory.

---
 rtl/sha256_nonce_engine.sv | 173 +++++++++++++++++
 tb/tb_sha256_nonce_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_engine.sv
// Second-block SHA-256 plus final SHA-256 over a nonce sweep; streams final H0 per nonce.
// One compression round per cycle, 16-word circular message schedule shared by both passes.
module sha256_nonce_engine #(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] midstate,
  input  logic [95:0]  tail,
  output logic         busy,
  output logic         done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_data,
  output logic [7:0]   res_nonce
);

  localparam int unsigned WORD_W = 32;
  localparam logic [7:0] LAST_NONCE = 8'(NUM_NONCES - 1);

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [WORD_W-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [3:0] {
    IDLE, LOAD1, RND1, FIN1, LOAD2, RND2, FIN2, OUT, DONE
  } state_t;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t              state;
  logic [255:0]        ms_q;
  logic [95:0]         tail_q;
  logic [7:0]          nonce;
  logic [5:0]          t;
  logic [WORD_W-1:0]   w [16];
  logic [WORD_W-1:0]   v [8];

  logic [3:0]          idx;
  logic [WORD_W-1:0]   w_t;
  logic [WORD_W-1:0]   t1;
  logic [WORD_W-1:0]   t2;

  // Round datapath; W[t-16] still sits at slot t mod 16 until this round overwrites it
  always_comb begin
    idx = t[3:0];
    w_t = w[idx];
    if (t >= 6'd16) begin
      w_t = ssig1(w[4'(idx - 4'd2)]) + w[4'(idx - 4'd7)] + ssig0(w[4'(idx - 4'd15)]) + w[idx];
    end
    t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w_t;
    t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ms_q      <= '0;
      tail_q    <= '0;
      nonce     <= '0;
      t         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_nonce <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++)  v[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ms_q   <= midstate;
            tail_q <= tail;
            nonce  <= '0;
            busy   <= 1'b1;
            state  <= LOAD1;
          end
        end
        LOAD1: begin
          w[0] <= tail_q[95:64];
          w[1] <= tail_q[63:32];
          w[2] <= tail_q[31:0];
          w[3] <= {24'h0, nonce};
          w[4] <= 32'h80000000;
          for (int i = 5; i < 15; i++) w[i] <= '0;
          w[15] <= 32'd640;
          for (int i = 0; i < 8; i++) v[i] <= ms_q[255-32*i -: 32];
          t     <= '0;
          state <= RND1;
        end
        RND1, RND2: begin
          w[idx] <= w_t;
          v[0]   <= t1 + t2;
          v[1]   <= v[0];
          v[2]   <= v[1];
          v[3]   <= v[2];
          v[4]   <= v[3] + t1;
          v[5]   <= v[4];
          v[6]   <= v[5];
          v[7]   <= v[6];
          t      <= t + 6'd1;
          if (t == 6'd63) state <= (state == RND1) ? FIN1 : FIN2;
        end
        // First-pass digest becomes the second-pass message directly in the schedule buffer
        FIN1: begin
          for (int i = 0; i < 8; i++) w[i] <= ms_q[255-32*i -: 32] + v[i];
          w[8] <= 32'h80000000;
          for (int i = 9; i < 15; i++) w[i] <= '0;
          w[15] <= 32'd256;
          state <= LOAD2;
        end
        LOAD2: begin
          for (int i = 0; i < 8; i++) v[i] <= IV[i];
          t     <= '0;
          state <= RND2;
        end
        FIN2: begin
          res_data  <= IV[0] + v[0];
          res_nonce <= nonce;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (nonce == LAST_NONCE) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              nonce <= nonce + 8'd1;
              state <= LOAD1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_engine.sv
// Directed bench for sha256_nonce_engine: reference double-SHA model, latency, backpressure and restart checks.
module tb_sha256_nonce_engine;

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [255:0] midstate;
  logic [95:0]  tail;
  logic         busy, done, res_valid, res_ready;
  logic [31:0]  res_data;
  logic [7:0]   res_nonce;

  logic         one_start;
  logic [255:0] one_midstate;
  logic [95:0]  one_tail;
  logic         one_busy, one_done, one_valid, one_ready;
  logic [31:0]  one_data;
  logic [7:0]   one_nonce;

  logic [255:0] mid_a, mid_b;
  logic [95:0]  tail_a, tail_b, tail_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sha256_nonce_engine #(.NUM_NONCES(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .midstate(midstate), .tail(tail),
    .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_nonce(res_nonce)
  );

  sha256_nonce_engine #(.NUM_NONCES(1)) u_one (
    .clk(clk), .reset_n(reset_n), .start(one_start), .midstate(one_midstate), .tail(one_tail),
    .busy(one_busy), .done(one_done), .res_valid(one_valid), .res_ready(one_ready),
    .res_data(one_data), .res_nonce(one_nonce)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression with a fully expanded 64-word schedule
  function automatic logic [255:0] sha_block(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
      t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
    return r;
  endfunction

  function automatic logic [31:0] model_h0(input logic [255:0] ms, input logic [95:0] tl, input int n);
    logic [511:0] blk1, blk2;
    logic [255:0] h1, h2;
    blk1 = {tl, 32'(n), 32'h80000000, 320'h0, 32'd640};
    h1   = sha_block(ms, blk1);
    blk2 = {h1, 32'h80000000, 192'h0, 32'd256};
    h2   = sha_block(IV256, blk2);
    return h2[255:224];
  endfunction

  function automatic logic [31:0] hdr_word(input int i);
    return (32'h01234567 * 32'(i + 1)) ^ 32'h9e3779b9;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy/done/valid %b%b%b expected 000", busy, done, res_valid); end
    checks++; if (res_data !== 32'h0 || res_nonce !== 8'h0) begin
      errors++; $display("FAIL reset_data: data %h nonce %h expected 0", res_data, res_nonce); end
    midstate = mid_a; tail = tail_a;
    pulse_start();
    repeat (30) @(negedge clk);
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_before: busy %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_async: busy/done/valid %b%b%b expected 000", busy, done, res_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 32'h0) begin
      errors++; $display("FAIL reset_idle: busy %b valid %b data %h expected 0 0 0", busy, res_valid, res_data); end
  endtask

  task automatic test_golden();
    int t0, n, extra;
    logic [31:0] exp;
    exp = model_h0(IV256, 96'h0, 0);
    one_midstate = IV256; one_tail = 96'h0; one_ready = 1'b1;
    one_start = 1'b1;
    @(negedge clk);
    one_start = 1'b0;
    t0 = cyc;
    n = 0;
    while (one_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++; if (one_valid !== 1'b1 || cyc - t0 !== 132) begin
      errors++; $display("FAIL golden_latency: valid %b after %0d cycles expected 1 after 132", one_valid, cyc - t0); end
    checks++; if (one_nonce !== 8'd0 || one_data !== exp) begin
      errors++; $display("FAIL golden_data: nonce %0d data %h expected 0 %h", one_nonce, one_data, exp); end
    @(negedge clk);
    checks++; if (one_valid !== 1'b0 || one_done !== 1'b1 || one_busy !== 1'b1) begin
      errors++; $display("FAIL golden_done: valid/done/busy %b%b%b expected 011", one_valid, one_done, one_busy); end
    @(negedge clk);
    checks++; if (one_done !== 1'b0 || one_busy !== 1'b0) begin
      errors++; $display("FAIL golden_done_fall: done/busy %b%b expected 00", one_done, one_busy); end
    extra = 0;
    repeat (150) begin @(negedge clk); if (one_valid === 1'b1) extra++; end
    checks++; if (extra !== 0) begin
      errors++; $display("FAIL golden_single: %0d extra valid cycles expected 0", extra); end
  endtask

  task automatic test_sweep();
    int t0, prev;
    logic [31:0] exp;
    midstate = mid_a; tail = tail_a; res_ready = 1'b1;
    pulse_start();
    t0 = cyc; prev = 0;
    for (int i = 0; i < 16; i++) begin
      wait_valid();
      exp = model_h0(mid_a, tail_a, i);
      checks++; if (res_valid !== 1'b1) begin
        errors++; $display("FAIL sweep_timeout %0d: res_valid %b expected 1", i, res_valid); end
      checks++; if ((i == 0 && cyc - t0 !== 132) || (i > 0 && cyc - prev !== 133)) begin
        errors++; $display("FAIL sweep_gap %0d: got %0d expected %0d", i, (i == 0) ? cyc - t0 : cyc - prev, (i == 0) ? 132 : 133); end
      checks++; if (res_nonce !== 8'(i) || res_data !== exp) begin
        errors++; $display("FAIL sweep_result %0d: nonce %0d data %h expected %0d %h", i, res_nonce, res_data, i, exp); end
      prev = cyc;
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL sweep_done: done/busy %b%b expected 11", done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL sweep_done_fall: done/busy %b%b expected 00", done, busy); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp, snap;
    logic stable;
    midstate = mid_a; tail = tail_a; res_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) res_ready = 1'b0;
      wait_valid();
      exp = model_h0(mid_a, tail_a, i);
      checks++; if (res_valid !== 1'b1 || res_nonce !== 8'(i) || res_data !== exp) begin
        errors++; $display("FAIL bp_result %0d: valid %b nonce %0d data %h expected 1 %0d %h", i, res_valid, res_nonce, res_data, i, exp); end
      if (i == 3) begin
        snap = res_data; stable = 1'b1;
        repeat (50) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_data !== snap || res_nonce !== 8'd3) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1 || snap !== exp) begin
          errors++; $display("FAIL bp_hold: stable %b data %h expected 1 %h", stable, res_data, exp); end
        res_ready = 1'b1;
      end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin
      errors++; $display("FAIL bp_done: done %b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp;
    midstate = mid_a; tail = tail_a; res_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        midstate = mid_b; tail = tail_b;
        pulse_start();
        checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin
          errors++; $display("FAIL swb_busy: busy %b valid %b expected 1 0", busy, res_valid); end
      end
      wait_valid();
      exp = model_h0(mid_a, tail_a, i);
      checks++; if (res_valid !== 1'b1 || res_nonce !== 8'(i) || res_data !== exp) begin
        errors++; $display("FAIL swb_result %0d: valid %b nonce %0d data %h expected 1 %0d %h", i, res_valid, res_nonce, res_data, i, exp); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin
      errors++; $display("FAIL swb_done: done %b expected 1", done); end
  endtask

  // Entered at the negedge inside the done pulse of the previous sweep
  task automatic test_back_to_back();
    int t0;
    logic [31:0] exp;
    midstate = mid_a; tail = tail_c;
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_ignored: busy/done %b%b expected 00", busy, done); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy %b expected 1", busy); end
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      wait_valid();
      exp = model_h0(mid_a, tail_c, i);
      if (i == 0) begin
        checks++; if (cyc - t0 !== 132) begin
          errors++; $display("FAIL b2b_latency: got %0d expected 132", cyc - t0); end
      end
      checks++; if (res_valid !== 1'b1 || res_nonce !== 8'(i) || res_data !== exp) begin
        errors++; $display("FAIL b2b_result %0d: valid %b nonce %0d data %h expected 1 %0d %h", i, res_valid, res_nonce, res_data, i, exp); end
      @(negedge clk);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end: done/busy %b%b expected 00", done, busy); end
  endtask

  initial begin
    logic [511:0] blk0;
    reset_n = 1'b0; start = 1'b0; res_ready = 1'b1;
    midstate = '0; tail = '0;
    one_start = 1'b0; one_ready = 1'b1; one_midstate = '0; one_tail = '0;
    for (int i = 0; i < 16; i++) blk0[511-32*i -: 32] = hdr_word(i);
    mid_a  = sha_block(IV256, blk0);
    tail_a = {hdr_word(16), hdr_word(17), hdr_word(18)};
    mid_b  = ~mid_a;
    tail_b = ~tail_a;
    tail_c = tail_a ^ 96'h1;

    test_reset();
    test_golden();
    test_sweep();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
